seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter. It drives a single-bit stream of a fixed N-bit

---
 rtl/seq_pattern_tx.sv | 185 ++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial transmitter for a fixed PAT_W-bit pattern, MSB first,
// repeated repeat_cnt times with gap_len zero bits between copies. last_bit
// marks the final pattern bit of every copy so a downstream detector can be
// checked in-band. All outputs are registered and cleared by the async reset.
module seq_pattern_tx #(
  parameter int                 PAT_W   = 5,
  parameter logic [PAT_W-1:0]   PATTERN = 5'b11101,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             ready,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       copy_cnt_r, copy_cnt_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [GAP_W-1:0] gap_len_r, gap_len_nxt_s;
  logic [7:0]       copies_left_s;
  logic             done_nxt_s;
  logic             x_out_nxt_s, x_valid_nxt_s, last_bit_nxt_s, busy_nxt_s;
  logic             x_out_r, x_valid_r, last_bit_r, busy_r, done_r;

  // Copies still owed after the current one; saturates so the counter never wraps.
  assign copies_left_s = (copy_cnt_r != 8'd0) ? (copy_cnt_r - 8'd1) : 8'd0;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= '0;
      copy_cnt_r <= 8'd0;
      gap_cnt_r  <= '0;
      gap_len_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      copy_cnt_r <= copy_cnt_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      gap_len_r  <= gap_len_nxt_s;
    end
  end

  // Next-state and counter update; abort beats both ready and start.
  always_comb begin
    state_nxt_s    = state_r;
    bit_idx_nxt_s  = bit_idx_r;
    copy_cnt_nxt_s = copy_cnt_r;
    gap_cnt_nxt_s  = gap_cnt_r;
    gap_len_nxt_s  = gap_len_r;
    done_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          if (repeat_cnt != 8'd0) begin
            state_nxt_s    = ST_SEND;
            bit_idx_nxt_s  = IDX_MSB;
            copy_cnt_nxt_s = repeat_cnt;
            gap_len_nxt_s  = gap_len;
            gap_cnt_nxt_s  = '0;
          end else begin
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt_s    = ST_IDLE;
          bit_idx_nxt_s  = '0;
          copy_cnt_nxt_s = 8'd0;
          gap_cnt_nxt_s  = '0;
        end else if (ready) begin
          if (bit_idx_r == '0) begin
            copy_cnt_nxt_s = copies_left_s;
            if (copies_left_s == 8'd0) begin
              state_nxt_s   = ST_IDLE;
              bit_idx_nxt_s = '0;
              done_nxt_s    = 1'b1;
            end else if (gap_len_r != '0) begin
              state_nxt_s   = ST_GAP;
              gap_cnt_nxt_s = gap_len_r;
            end else begin
              bit_idx_nxt_s = IDX_MSB;
            end
          end else begin
            bit_idx_nxt_s = bit_idx_r - IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt_s    = ST_IDLE;
          bit_idx_nxt_s  = '0;
          copy_cnt_nxt_s = 8'd0;
          gap_cnt_nxt_s  = '0;
        end else if (ready) begin
          if (gap_cnt_r <= GAP_W'(1)) begin
            state_nxt_s   = ST_SEND;
            bit_idx_nxt_s = IDX_MSB;
            gap_cnt_nxt_s = '0;
          end else begin
            gap_cnt_nxt_s = gap_cnt_r - GAP_W'(1);
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    x_out_nxt_s    = 1'b0;
    x_valid_nxt_s  = 1'b0;
    last_bit_nxt_s = 1'b0;
    busy_nxt_s     = 1'b0;
    case (state_nxt_s)
      ST_SEND: begin
        x_out_nxt_s    = PATTERN[bit_idx_nxt_s];
        x_valid_nxt_s  = 1'b1;
        last_bit_nxt_s = (bit_idx_nxt_s == '0);
        busy_nxt_s     = 1'b1;
      end
      ST_GAP: begin
        x_valid_nxt_s = 1'b1;
        busy_nxt_s    = 1'b1;
      end
      default: begin
        x_out_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers, so no input reaches a port combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out_r    <= 1'b0;
      x_valid_r  <= 1'b0;
      last_bit_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      x_out_r    <= x_out_nxt_s;
      x_valid_r  <= x_valid_nxt_s;
      last_bit_r <= last_bit_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign x_out    = x_out_r;
  assign x_valid  = x_valid_r;
  assign last_bit = last_bit_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus randomized ready/start
// traffic checked against a queue of expected stream bits built from the
// pattern/repeat/gap rules. Observed vector is {x_valid,x_out,last_bit,busy,done}.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       ready;
  logic       abort;
  logic       x_out, x_valid, last_bit, busy, done;

  int checks = 0;
  int errors = 0;

  logic [4:0] pat = 5'b11101;
  logic [1:0] exp_q[$];  // {x_out, last_bit} per stream bit

  always #5 clk = ~clk;

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt),
    .gap_len(gap_len), .ready(ready), .abort(abort), .x_out(x_out),
    .x_valid(x_valid), .last_bit(last_bit), .busy(busy), .done(done)
  );

  // Reference stream: r copies of the pattern, g zeros between copies only.
  task automatic build_stream(input int r, input int g);
    exp_q.delete();
    for (int c = 0; c < r; c++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back({pat[b], (b == 0) ? 1'b1 : 1'b0});
      if (c < r - 1) for (int k = 0; k < g; k++) exp_q.push_back(2'b00);
    end
  endtask

  task automatic launch(input int r, input int g);
    repeat_cnt = r[7:0]; gap_len = g[3:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; repeat_cnt = 8'd0; gap_len = 4'd0; ready = 1'b0; abort = 1'b0;
    #12;
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00000) begin
      errors++; $display("FAIL reset: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00000);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    ready = 1'b1;
    launch(1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({x_valid, x_out, last_bit, busy, done} !== {1'b1, pat[4-i], (i == 4), 1'b1, 1'b0}) begin
        errors++; $display("FAIL single bit%0d: got %b expected %b", i, {x_valid, x_out, last_bit, busy, done}, {1'b1, pat[4-i], (i == 4), 1'b1, 1'b0});
      end
      @(negedge clk);
    end
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00001) begin
      errors++; $display("FAIL single done: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00001);
    end
    @(negedge clk);
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00000) begin
      errors++; $display("FAIL single idle: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00000);
    end
  endtask

  task automatic test_gapped();
    int n;
    ready = 1'b1;
    build_stream(3, 2);
    n = exp_q.size();
    checks++;
    if (n != 19) begin errors++; $display("FAIL gapped length: got %0d expected 19", n); end
    launch(3, 2);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({x_valid, x_out, last_bit, busy, done} !== {1'b1, exp_q[i], 1'b1, 1'b0}) begin
        errors++; $display("FAIL gapped bit%0d: got %b expected %b", i, {x_valid, x_out, last_bit, busy, done}, {1'b1, exp_q[i], 1'b1, 1'b0});
      end
      @(negedge clk);
    end
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00001) begin
      errors++; $display("FAIL gapped done: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00001);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits = 10'b1110111101;
    int lasts = 0;
    ready = 1'b1;
    launch(2, 0);
    for (int i = 0; i < 10; i++) begin
      if (last_bit) lasts++;
      checks++;
      if ({x_valid, x_out, last_bit, busy} !== {1'b1, bits[9-i], (i == 4 || i == 9), 1'b1}) begin
        errors++; $display("FAIL b2b bit%0d: got %b expected %b", i, {x_valid, x_out, last_bit, busy}, {1'b1, bits[9-i], (i == 4 || i == 9), 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if (lasts != 2 || done !== 1'b1) begin
      errors++; $display("FAIL b2b lasts/done: got %0d/%b expected 2/1", lasts, done);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_start_ignored();
    int b;
    ready = 1'b1;
    launch(1, 0);
    for (int c = 0; c < 8; c++) begin
      b = (c < 3) ? c : ((c < 6) ? 2 : c - 3);
      checks++;
      if ({x_valid, x_out, last_bit, busy, done} !== {1'b1, pat[4-b], (b == 4), 1'b1, 1'b0}) begin
        errors++; $display("FAIL stall c%0d: got %b expected %b", c, {x_valid, x_out, last_bit, busy, done}, {1'b1, pat[4-b], (b == 4), 1'b1, 1'b0});
      end
      ready = (c < 2 || c >= 5);
      start = (c == 2);
      repeat_cnt = 8'd5; gap_len = 4'd3;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if ({x_valid, busy, done} !== 3'b001) begin
      errors++; $display("FAIL stall done: got %b expected %b", {x_valid, busy, done}, 3'b001);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({x_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL stall no extra copy: got %b expected %b", {x_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_zero_and_abort();
    ready = 1'b1;
    launch(0, 2);
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00001) begin
      errors++; $display("FAIL zero done: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00001);
    end
    @(negedge clk);
    checks++;
    if ({x_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL zero idle: got %b expected %b", {x_valid, busy, done}, 3'b000);
    end
    launch(2, 1);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({x_valid, x_out, busy} !== 3'b111) begin
      errors++; $display("FAIL abort pre: got %b expected %b", {x_valid, x_out, busy}, 3'b111);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00000) begin
      errors++; $display("FAIL abort: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00000);
    end
    @(negedge clk);
    checks++;
    if ({x_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL abort no done: got %b expected %b", {x_valid, busy, done}, 3'b000);
    end
    abort = 1'b1;
    launch(1, 0);
    abort = 1'b0;
    checks++;
    if ({x_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL idle abort over start: got %b expected %b", {x_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    launch(3, 3);
    repeat (5) @(negedge clk);
    checks++;
    if ({x_valid, x_out, last_bit, busy} !== 4'b1001) begin
      errors++; $display("FAIL in gap: got %b expected %b", {x_valid, x_out, last_bit, busy}, 4'b1001);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({x_valid, x_out, last_bit, busy, done} !== 5'b00000) begin
      errors++; $display("FAIL async reset: got %b expected %b", {x_valid, x_out, last_bit, busy, done}, 5'b00000);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    launch(1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({x_valid, x_out, last_bit, busy} !== {1'b1, pat[4-i], (i == 4), 1'b1}) begin
        errors++; $display("FAIL post-reset bit%0d: got %b expected %b", i, {x_valid, x_out, last_bit, busy}, {1'b1, pat[4-i], (i == 4), 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL post-reset done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int r, g, budget;
      r = $urandom_range(1, 6);
      g = $urandom_range(0, 3);
      build_stream(r, g);
      ready = ($urandom_range(0, 1) != 0);
      launch(r, g);
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
        checks++;
        if ({x_valid, x_out, last_bit, busy, done} !== {1'b1, exp_q[0], 1'b1, 1'b0}) begin
          errors++; $display("FAIL random t%0d: got %b expected %b", t, {x_valid, x_out, last_bit, busy, done}, {1'b1, exp_q[0], 1'b1, 1'b0});
        end
        ready = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 7) == 0);
        repeat_cnt = 8'($urandom);
        gap_len = 4'($urandom);
        if (ready) void'(exp_q.pop_front());
        @(negedge clk);
        budget++;
      end
      start = 1'b0;
      checks++;
      if (budget >= 500) begin errors++; $display("FAIL random t%0d timeout: got budget %0d expected < 500", t, budget); end
      checks++;
      if ({x_valid, busy, done} !== 3'b001) begin
        errors++; $display("FAIL random t%0d done: got %b expected %b", t, {x_valid, busy, done}, 3'b001);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_stall_start_ignored();
    test_zero_and_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
